// File: rtl/display_pkg.sv
// display_pkg: definitions shared by the HDMI display path blocks
// (timing generator, data control, frame read scheduler).
//   H_ACTIVE / V_ACTIVE : visible raster size
//   FRAME_WORDS         : 16-bit words in one visible frame
//   DEF_BASE0/DEF_BASE1 : default SDRAM bases of the two frame buffers
//   rd_state_t          : frame read scheduler states
package display_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;

  localparam logic [23:0] DEF_BASE0 = 24'h000000;
  localparam logic [23:0] DEF_BASE1 = 24'h080000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_XFER
  } rd_state_t;

endpackage

// File: rtl/hdmi_frame_rd_sched.sv
// hdmi_frame_rd_sched: streams one frame per vsync from the double-buffered
// SDRAM frame store into the display FIFO as a sequence of burst reads,
// issuing a burst only when the FIFO has room for all of it. The displayed
// bank flips at a frame start only after the writer has completed a frame.
//
// Ports (all in the hdmi_clk domain, rst asynchronous active-high):
//   frame_start   in   vsync-start pulse
//   wr_frame_done in   writer finished a frame (arms a bank swap)
//   fifo_level    in   display FIFO fill count
//   rd_req/rd_addr/rd_len out, rd_ack in : burst request handshake
//   rd_done       in   last word of the accepted burst is in the FIFO
//   fifo_clr      out  FIFO clear, CLR_CYCLES long at each frame start
//   rd_bank       out  bank being displayed
//   busy          out  frame in progress
//   frame_late    out  frame_start arrived before the previous frame finished
module hdmi_frame_rd_sched #(
  parameter int                H_ACTIVE   = display_pkg::H_ACTIVE,
  parameter int                V_ACTIVE   = display_pkg::V_ACTIVE,
  parameter int                BURST_LEN  = 256,
  parameter int                FIFO_DEPTH = 1024,
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE0      = ADDR_W'(display_pkg::DEF_BASE0),
  parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(display_pkg::DEF_BASE1),
  parameter int                CLR_CYCLES = 4
) (
  input  logic              hdmi_clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              wr_frame_done,
  input  logic [10:0]       fifo_level,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [8:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              fifo_clr,
  output logic              rd_bank,
  output logic              busy,
  output logic              frame_late
);

  import display_pkg::*;

  localparam int FRM_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int REM_W     = $clog2(FRM_WORDS + 1);
  localparam int CNT_W     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int FIRST_LEN = (FRM_WORDS < BURST_LEN) ? FRM_WORDS : BURST_LEN;

  rd_state_t        state_reg;
  logic [REM_W-1:0] remaining_reg;
  logic [CNT_W-1:0] clr_cnt_reg;
  logic             swap_pend_reg;
  logic             restart_pend_reg;

  logic              do_start;
  logic              bank_next;
  logic [ADDR_W-1:0] base_next;
  logic [REM_W-1:0]  rem_next;
  logic              space_ok;

  // Burst length for a given number of words still to fetch.
  function automatic logic [8:0] burst_len_for(input logic [REM_W-1:0] rem);
    logic [31:0] rem32;
    rem32 = 32'(rem);
    if (rem32 >= 32'(BURST_LEN))
      return 9'(BURST_LEN);
    else
      return 9'(rem);
  endfunction

  // A frame start takes effect immediately unless a burst handshake is in
  // flight; in that case it is held in restart_pend and taken at rd_done
  // (a frame_start landing on that very rd_done counts as well).
  always_comb begin
    do_start = 1'b0;
    case (state_reg)
      ST_IDLE, ST_CLEAR, ST_WAIT_SPACE: do_start = frame_start;
      ST_XFER:                          do_start = rd_done & (restart_pend_reg | frame_start);
      default:                          do_start = 1'b0;
    endcase
  end

  // A wr_frame_done coinciding with the start applies to that same frame.
  assign bank_next = rd_bank ^ (swap_pend_reg | wr_frame_done);
  assign base_next = bank_next ? BASE1 : BASE0;
  assign rem_next  = remaining_reg - REM_W'(rd_len);
  // rd_len always holds min(BURST_LEN, remaining), so it is the size to test.
  assign space_ok  = (32'(fifo_level) + 32'(rd_len)) <= 32'(FIFO_DEPTH);

  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      remaining_reg    <= '0;
      clr_cnt_reg      <= '0;
      swap_pend_reg    <= 1'b0;
      restart_pend_reg <= 1'b0;
      rd_req           <= 1'b0;
      rd_addr          <= BASE0;
      rd_len           <= '0;
      fifo_clr         <= 1'b0;
      rd_bank          <= 1'b0;
      busy             <= 1'b0;
      frame_late       <= 1'b0;
    end else begin
      frame_late <= frame_start && (state_reg != ST_IDLE) && (remaining_reg != '0);

      if (do_start) begin
        rd_bank          <= bank_next;
        swap_pend_reg    <= 1'b0;
        restart_pend_reg <= 1'b0;
        rd_addr          <= base_next;
        remaining_reg    <= REM_W'(FRM_WORDS);
        rd_len           <= 9'(FIRST_LEN);
        clr_cnt_reg      <= CNT_W'(CLR_CYCLES - 1);
        fifo_clr         <= 1'b1;
        busy             <= 1'b1;
        rd_req           <= 1'b0;
        state_reg        <= ST_CLEAR;
      end else begin
        if (wr_frame_done)
          swap_pend_reg <= 1'b1;

        case (state_reg)
          ST_IDLE: begin
          end

          ST_CLEAR: begin
            if (clr_cnt_reg == '0) begin
              fifo_clr  <= 1'b0;
              state_reg <= ST_WAIT_SPACE;
            end else begin
              clr_cnt_reg <= clr_cnt_reg - 1'b1;
            end
          end

          ST_WAIT_SPACE: begin
            if (remaining_reg == '0) begin
              busy      <= 1'b0;
              state_reg <= ST_IDLE;
            end else if (space_ok) begin
              rd_req    <= 1'b1;
              state_reg <= ST_REQ;
            end
          end

          ST_REQ: begin
            if (frame_start)
              restart_pend_reg <= 1'b1;
            if (rd_ack) begin
              rd_req    <= 1'b0;
              state_reg <= ST_XFER;
            end
          end

          ST_XFER: begin
            if (frame_start)
              restart_pend_reg <= 1'b1;
            if (rd_done) begin
              rd_addr       <= rd_addr + ADDR_W'(rd_len);
              remaining_reg <= rem_next;
              rd_len        <= burst_len_for(rem_next);
              state_reg     <= ST_WAIT_SPACE;
            end
          end

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_frame_rd_sched.sv
// Bench for hdmi_frame_rd_sched.
//   u_dut : default 640x480 geometry, directed sequences and a throttle table.
//   u_odd : 100x3 geometry (bursts of 256 then 44), random stimulus checked
//           against a frame/burst-level model of the scheduler.
module tb_hdmi_frame_rd_sched;

  localparam logic [23:0] B0          = 24'h000000;
  localparam logic [23:0] B1          = 24'h080000;
  localparam int          ODD_WORDS   = 300;
  localparam int          ODD_BURSTS  = 2;
  localparam int          FULL_BURSTS = 1200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-geometry instance
  logic        frame_start, wr_frame_done, rd_ack, rd_done;
  logic [10:0] fifo_level;
  logic        rd_req, fifo_clr, rd_bank, busy, frame_late;
  logic [23:0] rd_addr;
  logic [8:0]  rd_len;

  // odd-geometry instance
  logic        o_fs, o_wfd, o_ack, o_done;
  logic [10:0] o_lvl;
  logic        o_req, o_clr, o_bank, o_busy, o_late;
  logic [23:0] o_addr;
  logic [8:0]  o_len;

  hdmi_frame_rd_sched u_dut (
    .hdmi_clk      (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .wr_frame_done (wr_frame_done),
    .fifo_level    (fifo_level),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .rd_ack        (rd_ack),
    .rd_done       (rd_done),
    .fifo_clr      (fifo_clr),
    .rd_bank       (rd_bank),
    .busy          (busy),
    .frame_late    (frame_late)
  );

  hdmi_frame_rd_sched #(.H_ACTIVE(100), .V_ACTIVE(3)) u_odd (
    .hdmi_clk      (clk),
    .rst           (rst),
    .frame_start   (o_fs),
    .wr_frame_done (o_wfd),
    .fifo_level    (o_lvl),
    .rd_req        (o_req),
    .rd_addr       (o_addr),
    .rd_len        (o_len),
    .rd_ack        (o_ack),
    .rd_done       (o_done),
    .fifo_clr      (o_clr),
    .rd_bank       (o_bank),
    .busy          (o_busy),
    .frame_late    (o_late)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected rd_req", name);
  endtask

  // Wait for a request, check it, ack after ack_dly cycles, complete after done_dly.
  task automatic main_burst(input logic [23:0] ea, input int ack_dly, input int done_dly);
    int w;
    w = 0;
    while (!rd_req && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!rd_req) begin
      timeout_fail("burst_wait");
      return;
    end
    check("burst_addr", 32'(rd_addr), 32'(ea));
    check("burst_len", 32'(rd_len), 32'd256);
    repeat (ack_dly) @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    check("burst_req_drop", 32'(rd_req), 32'd0);
    repeat (done_dly) @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  // Reference burst layout of the odd frame: burst k of a bank.
  function automatic logic [23:0] odd_addr(input logic bank, input int k);
    return (bank ? B1 : B0) + 24'(k * 256);
  endfunction

  function automatic int odd_len(input int k);
    int r;
    r = ODD_WORDS - k * 256;
    return (r < 256) ? r : 256;
  endfunction

  typedef struct {
    logic [10:0] lvl;
    logic        exp_req;
  } thr_vec_t;

  thr_vec_t tv [8];

  // odd-instance model state
  logic m_started, m_bank, m_swap, m_restart, m_inxfer;
  int   m_k, m_clr_left, m_frames, m_xfers;
  logic p_req;
  logic [23:0] p_addr;
  logic [8:0]  p_len;
  logic late_exp, accepted, started_now, rise_ok;

  int   n, w, k;
  logic seen;

  initial begin
    tv[0] = '{11'd900,  1'b0};
    tv[1] = '{11'd769,  1'b0};
    tv[2] = '{11'd768,  1'b1};
    tv[3] = '{11'd2047, 1'b0};
    tv[4] = '{11'd1025, 1'b0};
    tv[5] = '{11'd0,    1'b1};
    tv[6] = '{11'd1023, 1'b0};
    tv[7] = '{11'd512,  1'b1};

    rst = 1'b1;
    frame_start = 0; wr_frame_done = 0; rd_ack = 0; rd_done = 0; fifo_level = '0;
    o_fs = 0; o_wfd = 0; o_ack = 0; o_done = 0; o_lvl = '0;

    // ---------------- reset and idle ----------------
    repeat (3) @(negedge clk);
    check("rst_req",  32'(rd_req),     32'd0);
    check("rst_addr", 32'(rd_addr),    32'(B0));
    check("rst_len",  32'(rd_len),     32'd0);
    check("rst_clr",  32'(fifo_clr),   32'd0);
    check("rst_bank", 32'(rd_bank),    32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_late", 32'(frame_late), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (rd_req || fifo_clr || busy) seen = 1'b1;
    end
    check("idle_quiet", 32'(seen), 32'd0);
    $display("reset/idle: outputs quiet for 1000 cycles");

    // ---------------- frame start and throttle table ----------------
    fifo_level = 11'd2047;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("start_clr",  32'(fifo_clr),   32'd1);
    check("start_busy", 32'(busy),       32'd1);
    check("start_late", 32'(frame_late), 32'd0);
    check("start_addr", 32'(rd_addr),    32'(B0));
    n = 0;
    while (fifo_clr && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("clr_cycles", 32'(n), 32'd4);

    k = 0;
    for (int r = 0; r < 8; r++) begin
      fifo_level = tv[r].lvl;
      @(negedge clk);
      check("thr_req", 32'(rd_req), 32'(tv[r].exp_req));
      $display("throttle row %0d: level=%0d rd_req=%0b", r, tv[r].lvl, rd_req);
      if (rd_req) begin
        check("thr_addr", 32'(rd_addr), 32'(k * 256));
        check("thr_len",  32'(rd_len),  32'd256);
        fifo_level = 11'd2047;
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check("thr_req_drop", 32'(rd_req), 32'd0);
        repeat (3) @(negedge clk);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        check("thr_addr_next", 32'(rd_addr), 32'((k + 1) * 256));
        check("thr_no_early_req", 32'(rd_req), 32'd0);
        k++;
      end
    end

    // ---------------- late frame: frame_start during XFER ----------------
    fifo_level = '0;
    w = 0;
    while (!rd_req && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!rd_req) timeout_fail("late_wait");
    check("late_burst_addr", 32'(rd_addr), 32'(k * 256));
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("late_pulse",  32'(frame_late), 32'd1);
    check("late_no_clr", 32'(fifo_clr),   32'd0);
    @(negedge clk);
    check("late_one_cycle", 32'(frame_late), 32'd0);
    check("late_still_no_clr", 32'(fifo_clr), 32'd0);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check("late_clr",  32'(fifo_clr), 32'd1);
    check("late_addr", 32'(rd_addr),  32'(B0));
    check("late_bank", 32'(rd_bank),  32'd0);
    check("late_busy", 32'(busy),     32'd1);
    $display("late frame: restart after burst completion, addr=0x%0h", rd_addr);

    // ---------------- full frame, writer finishes mid-frame ----------------
    for (int i = 0; i < FULL_BURSTS; i++) begin
      if (i == 600) begin
        wr_frame_done = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
      end
      main_burst(24'(i * 256), 3, 6);
    end
    check("full_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("full_busy_fall", 32'(busy), 32'd0);
    check("full_bank", 32'(rd_bank), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rd_req) seen = 1'b1;
    end
    check("full_no_extra_req", 32'(seen), 32'd0);
    $display("full frame: %0d bursts, last addr=0x%0h", FULL_BURSTS, (FULL_BURSTS - 1) * 256);

    // ---------------- bank swap, then a start without a new write ----------------
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("swap_bank",  32'(rd_bank),    32'd1);
    check("swap_late",  32'(frame_late), 32'd0);
    check("swap_addr",  32'(rd_addr),    32'(B1));
    main_burst(B1, 0, 2);
    main_burst(B1 + 24'd256, 1, 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("keep_bank", 32'(rd_bank),    32'd1);
    check("keep_late", 32'(frame_late), 32'd1);
    check("keep_clr",  32'(fifo_clr),   32'd1);
    check("keep_addr", 32'(rd_addr),    32'(B1));
    main_burst(B1, 1, 1);
    fifo_level = 11'd2047;
    $display("bank swap: rd_bank=%0b first addr=0x%0h", rd_bank, rd_addr);

    // ---------------- random stimulus on the odd-geometry instance ----------------
    m_started = 0; m_bank = 0; m_swap = 0; m_restart = 0; m_inxfer = 0;
    m_k = 0; m_clr_left = 0; m_frames = 0; m_xfers = 0;
    p_req = 0; p_addr = '0; p_len = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      // Inputs currently applied are the ones the edge just sampled.
      late_exp = o_fs && m_started && (m_k < ODD_BURSTS);
      check("rnd_late", 32'(o_late), 32'(late_exp));
      accepted = p_req && o_ack;
      if (accepted) begin
        check("rnd_addr", 32'(p_addr), 32'(odd_addr(m_bank, m_k)));
        check("rnd_len",  32'(p_len),  32'(odd_len(m_k)));
        check("rnd_req_fall", 32'(o_req), 32'd0);
        m_xfers++;
      end
      started_now = 1'b0;
      if (m_inxfer && o_done) begin
        m_inxfer = 1'b0;
        if (m_restart || o_fs) started_now = 1'b1;
        else m_k++;
      end else if (o_fs) begin
        if (p_req || m_inxfer) m_restart = 1'b1;
        else started_now = 1'b1;
      end
      if (started_now) begin
        m_bank     = m_bank ^ (m_swap | o_wfd);
        m_swap     = 1'b0;
        m_restart  = 1'b0;
        m_k        = 0;
        m_started  = 1'b1;
        m_clr_left = 4;
        m_frames++;
      end else begin
        if (o_wfd) m_swap = 1'b1;
        if (m_clr_left > 0) m_clr_left--;
      end
      if (accepted) m_inxfer = 1'b1;
      check("rnd_clr",  32'(o_clr),  32'(m_clr_left > 0));
      check("rnd_bank", 32'(o_bank), 32'(m_bank));
      if (o_req && !p_req) begin
        rise_ok = (m_k < ODD_BURSTS) && ((int'(o_lvl) + odd_len(m_k)) <= 1024);
        check("rnd_req_rise", 32'(rise_ok), 32'd1);
      end
      p_req  = o_req;
      p_addr = o_addr;
      p_len  = o_len;
      o_fs   = ($urandom_range(0, 149) == 0);
      o_wfd  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) o_lvl = 11'($urandom_range(0, 1100));
      o_ack  = o_req    ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      o_done = m_inxfer ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
    end
    o_fs = 0; o_wfd = 0; o_ack = 0; o_done = 0;
    check("rnd_activity", 32'(m_xfers > 20), 32'd1);
    $display("random: %0d frames started, %0d bursts accepted", m_frames, m_xfers);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
